// File: rtl/multicore_ring_node_array_if.sv
// rtl/multicore_ring_node_array_if.sv - memory-side request/response bundle of the core ring
interface multicore_ring_node_array_if;
  logic        io_prev_valid;
  logic        io_prev_ready;
  logic [31:0] io_prev_bits_address;
  logic        io_prev_bits_wen;
  logic [31:0] io_prev_bits_data;
  logic [7:0]  io_prev_bits_id;
  logic        io_next_valid;
  logic        io_next_ready;
  logic [31:0] io_next_bits_address;
  logic [31:0] io_next_bits_data;
  logic        io_next_bits_wen;
  logic [7:0]  io_next_bits_id;
  logic        io_halted;

  modport slave (
    input  io_prev_valid, io_prev_bits_address, io_prev_bits_wen, io_prev_bits_data,
           io_prev_bits_id, io_next_ready,
    output io_prev_ready, io_next_valid, io_next_bits_address, io_next_bits_data,
           io_next_bits_wen, io_next_bits_id, io_halted
  );

  modport master (
    output io_prev_valid, io_prev_bits_address, io_prev_bits_wen, io_prev_bits_data,
           io_prev_bits_id, io_next_ready,
    input  io_prev_ready, io_next_valid, io_next_bits_address, io_next_bits_data,
           io_next_bits_wen, io_next_bits_id, io_halted
  );
endinterface

// File: rtl/multicore_ring_node_array.sv
// rtl/multicore_ring_node_array.sv - ring of NUM_CORES MIPS-subset cores sharing one memory port
// Define MULTICORE_RING_HALT_ON_ILLEGAL_EN to halt a core on an unsupported opcode (default: NOP).
module multicore_ring_node_array #(
  parameter int NUM_CORES = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  multicore_ring_node_array_if.slave  ring
);
  localparam logic [2:0] S_FETCH = 3'd0, S_WAITI = 3'd1, S_EXEC = 3'd2,
                         S_MEM   = 3'd3, S_WAITD = 3'd4, S_HALT = 3'd5;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_ADDI = 6'h08, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_BREAK = 6'h0D, FN_ADDU = 6'h21, FN_AND = 6'h24,
                         FN_OR = 6'h25, FN_XOR = 6'h26;
`ifdef MULTICORE_RING_HALT_ON_ILLEGAL_EN
  localparam bit HALT_ON_ILLEGAL = 1'b1;
`else
  localparam bit HALT_ON_ILLEGAL = 1'b0;
`endif

  logic [NUM_CORES-1:0] sv_q, sv_d, sr_q, sr_d, sw_q, sw_d;
  logic [31:0] sa_q [NUM_CORES], sa_d [NUM_CORES], sd_q [NUM_CORES], sd_d [NUM_CORES];
  logic [7:0]  si_q [NUM_CORES], si_d [NUM_CORES];
  logic [2:0]  st_q [NUM_CORES], st_d [NUM_CORES];
  logic [31:0] pc_q [NUM_CORES], pc_d [NUM_CORES], ir_q [NUM_CORES], ir_d [NUM_CORES];
  logic [31:0] rf_q [NUM_CORES][32], rf_d [NUM_CORES][32];

  logic [NUM_CORES-1:0] rdy, consume, out_fire, inject, req_v, req_w, halted;
  logic [31:0] req_a [NUM_CORES], req_dat [NUM_CORES];

  always_comb begin
    logic        carry, last, up_v, up_r, up_w, wr, illegal;
    logic [31:0] up_a, up_d, ir, rs_v, rt_v, simm, wval;
    logic [7:0]  up_i;
    logic [4:0]  wdst;
    carry = 1'b0; last = 1'b0; up_v = 1'b0; up_r = 1'b0; up_w = 1'b0;
    wr = 1'b0; illegal = 1'b0; up_a = '0; up_d = '0; up_i = '0;
    ir = '0; rs_v = '0; rt_v = '0; simm = '0; wval = '0; wdst = '0;
    sv_d = sv_q; sr_d = sr_q; sw_d = sw_q; sa_d = sa_q; sd_d = sd_q; si_d = si_q;
    st_d = st_q; pc_d = pc_q; ir_d = ir_q; rf_d = rf_q;
    rdy = '0; consume = '0; out_fire = '0; inject = '0; req_v = '0; req_w = '0; halted = '0;

    for (int k = 0; k < NUM_CORES; k++) begin
      ir = ir_q[k];
      halted[k]  = (st_q[k] == S_HALT);
      req_v[k]   = (st_q[k] == S_FETCH) || (st_q[k] == S_MEM);
      req_w[k]   = (st_q[k] == S_MEM) && (ir[31:26] == OP_SW);
      req_a[k]   = (st_q[k] == S_FETCH) ? pc_q[k]
                 : rf_q[k][ir[25:21]] + {{16{ir[15]}}, ir[15:0]};
      req_dat[k] = req_w[k] ? rf_q[k][ir[20:16]] : {24'd0, 8'(k)};
    end

    // Ready ripples from the memory side back to stage 0; the last stage always drains responses.
    carry = ring.io_next_ready;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      last        = (k == NUM_CORES - 1);
      consume[k]  = sv_q[k] & sr_q[k] & (si_q[k] == 8'(k));
      out_fire[k] = sv_q[k] & (consume[k] | carry | (last & sr_q[k]));
      rdy[k]      = ~sv_q[k] | out_fire[k];
      carry       = rdy[k];
    end

    up_v = ring.io_prev_valid; up_r = 1'b1; up_w = ring.io_prev_bits_wen;
    up_a = ring.io_prev_bits_address; up_d = ring.io_prev_bits_data; up_i = ring.io_prev_bits_id;
    for (int k = 0; k < NUM_CORES; k++) begin
      inject[k] = rdy[k] & ~up_v & req_v[k];
      if (up_v && rdy[k]) begin
        sv_d[k] = 1'b1; sr_d[k] = up_r; sw_d[k] = up_w;
        sa_d[k] = up_a; sd_d[k] = up_d; si_d[k] = up_i;
      end else if (inject[k]) begin
        sv_d[k] = 1'b1; sr_d[k] = 1'b0; sw_d[k] = req_w[k];
        sa_d[k] = req_a[k]; sd_d[k] = req_dat[k]; si_d[k] = 8'(k);
      end else if (out_fire[k]) begin
        sv_d[k] = 1'b0;
      end
      up_v = sv_q[k] & ~consume[k]; up_r = sr_q[k]; up_w = sw_q[k];
      up_a = sa_q[k]; up_d = sd_q[k]; up_i = si_q[k];
    end

    for (int k = 0; k < NUM_CORES; k++) begin
      ir   = ir_q[k];
      rs_v = rf_q[k][ir[25:21]];
      rt_v = rf_q[k][ir[20:16]];
      simm = {{16{ir[15]}}, ir[15:0]};
      wr = 1'b0; wdst = ir[20:16]; wval = '0; illegal = 1'b0;
      case (st_q[k])
        S_FETCH: if (inject[k]) st_d[k] = S_WAITI;
        S_WAITI: if (consume[k]) begin ir_d[k] = sd_q[k]; st_d[k] = S_EXEC; end
        S_EXEC: begin
          st_d[k] = S_FETCH;
          pc_d[k] = pc_q[k] + 32'd4;
          case (ir[31:26])
            OP_RTYPE: begin
              wdst = ir[15:11];
              wr   = (ir[10:6] == 5'd0);
              case (ir[5:0])
                FN_ADDU: wval = rs_v + rt_v;
                FN_XOR:  wval = rs_v ^ rt_v;
                FN_OR:   wval = rs_v | rt_v;
                FN_AND:  wval = rs_v & rt_v;
                FN_BREAK: begin wr = 1'b0; st_d[k] = S_HALT; pc_d[k] = pc_q[k]; end
                default: wr = 1'b0;
              endcase
              illegal = ~wr && (ir[5:0] != FN_BREAK);
            end
            OP_ADDI: begin wr = 1'b1; wval = rs_v + simm; end
            OP_LUI:  begin wr = 1'b1; wval = {ir[15:0], 16'd0}; end
            OP_BEQ:  if (rs_v == rt_v) pc_d[k] = pc_q[k] + 32'd4 + {simm[29:0], 2'b00};
            OP_BNE:  if (rs_v != rt_v) pc_d[k] = pc_q[k] + 32'd4 + {simm[29:0], 2'b00};
            OP_J:    pc_d[k] = {pc_q[k][31:28], ir[25:0], 2'b00};
            OP_LW, OP_SW: begin st_d[k] = S_MEM; pc_d[k] = pc_q[k]; end
            default: illegal = 1'b1;
          endcase
          if (illegal && HALT_ON_ILLEGAL) begin st_d[k] = S_HALT; pc_d[k] = pc_q[k]; end
          if (wr && wdst != 5'd0) rf_d[k][wdst] = wval;
        end
        // Stores retire as soon as the ring takes them; loads wait for their data.
        S_MEM: if (inject[k]) begin
          if (req_w[k]) begin st_d[k] = S_FETCH; pc_d[k] = pc_q[k] + 32'd4; end
          else st_d[k] = S_WAITD;
        end
        S_WAITD: if (consume[k]) begin
          if (ir[20:16] != 5'd0) rf_d[k][ir[20:16]] = sd_q[k];
          pc_d[k] = pc_q[k] + 32'd4;
          st_d[k] = S_FETCH;
        end
        S_HALT: st_d[k] = S_HALT;
        default: st_d[k] = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sv_q <= '0; sr_q <= '0; sw_q <= '0;
      for (int k = 0; k < NUM_CORES; k++) begin
        sa_q[k] <= '0; sd_q[k] <= '0; si_q[k] <= '0;
        st_q[k] <= S_FETCH; pc_q[k] <= '0; ir_q[k] <= '0;
        for (int r = 0; r < 32; r++) rf_q[k][r] <= '0;
      end
    end else begin
      sv_q <= sv_d; sr_q <= sr_d; sw_q <= sw_d;
      sa_q <= sa_d; sd_q <= sd_d; si_q <= si_d;
      st_q <= st_d; pc_q <= pc_d; ir_q <= ir_d; rf_q <= rf_d;
    end
  end

  assign ring.io_prev_ready        = rdy[0];
  assign ring.io_next_valid        = sv_q[NUM_CORES-1] & ~sr_q[NUM_CORES-1];
  assign ring.io_next_bits_address = sa_q[NUM_CORES-1];
  assign ring.io_next_bits_data    = sd_q[NUM_CORES-1];
  assign ring.io_next_bits_wen     = sw_q[NUM_CORES-1];
  assign ring.io_next_bits_id      = si_q[NUM_CORES-1];
  assign ring.io_halted            = &halted;
endmodule

// File: tb/tb_multicore_ring_node_array.sv
// tb/tb_multicore_ring_node_array.sv - directed bench for the two-core ring with a shared memory model
module tb_multicore_ring_node_array;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicore_ring_node_array_if ring();
  multicore_ring_node_array #(.NUM_CORES(2)) dut (.clock(clk), .reset(rst_n), .ring(ring));

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wen;
    logic [7:0]  id;
  } pkt_t;
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  id;
  } rsp_t;

  pkt_t        log_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] mem [64];
  bit          auto_rsp;
  bit          next_rdy;
  int          checks = 0;
  int          failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic pkt_t pk(input int i);
    if (i < log_q.size()) return log_q[i];
    return '1;
  endfunction

  // One clock: drive inputs after the edge, then record handshakes that the next edge commits.
  task automatic tick();
    @(posedge clk); #1;
    ring.io_next_ready = next_rdy;
    if (rsp_q.size() > 0) begin
      ring.io_prev_valid     = 1'b1;
      ring.io_prev_bits_data = rsp_q[0].data;
      ring.io_prev_bits_id   = rsp_q[0].id;
    end else begin
      ring.io_prev_valid     = 1'b0;
      ring.io_prev_bits_data = '0;
      ring.io_prev_bits_id   = '0;
    end
    #1;
    if (rst_n) begin
      if (ring.io_prev_valid && ring.io_prev_ready) void'(rsp_q.pop_front());
      if (ring.io_next_valid && ring.io_next_ready) begin
        log_q.push_back(pkt_t'{addr: ring.io_next_bits_address, data: ring.io_next_bits_data,
                               wen: ring.io_next_bits_wen, id: ring.io_next_bits_id});
        if (ring.io_next_bits_wen) mem[ring.io_next_bits_address[7:2]] = ring.io_next_bits_data;
        else if (auto_rsp)
          rsp_q.push_back(rsp_t'{data: mem[ring.io_next_bits_address[7:2]], id: ring.io_next_bits_id});
      end
    end
  endtask

  initial begin
    pkt_t        snap, p;
    pkt_t        p0[$];
    bit          stable;
    int          nwr;
    logic [31:0] exp_addr [11];
    logic        exp_wen [11];

    next_rdy = 1'b1; auto_rsp = 1'b0;
    ring.io_prev_valid = 1'b0; ring.io_prev_bits_address = '0; ring.io_prev_bits_wen = 1'b0;
    ring.io_prev_bits_data = '0; ring.io_prev_bits_id = '0; ring.io_next_ready = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_next_valid", ring.io_next_valid, 0);
    check_eq("rst_prev_ready", ring.io_prev_ready, 1);
    check_eq("rst_halted", ring.io_halted, 0);
    rst_n = 1'b1;

    repeat (6) tick();
    check_eq("first_count", log_q.size(), 2);
    check_eq("first_id", pk(0).id, 1);
    check_eq("first_addr", pk(0).addr, 0);
    check_eq("first_data", pk(0).data, 1);
    check_eq("first_wen", pk(0).wen, 0);
    check_eq("second_id", pk(1).id, 0);
    check_eq("second_addr", pk(1).addr, 0);
    check_eq("second_data", pk(1).data, 0);
    check_eq("idle_next_valid", ring.io_next_valid, 0);

    log_q.delete();
    rsp_q.push_back(rsp_t'{data: 32'h00631826, id: 8'd0});
    repeat (12) tick();
    check_eq("xor_count", log_q.size(), 1);
    check_eq("xor_next_id", pk(0).id, 0);
    check_eq("xor_next_addr", pk(0).addr, 4);
    check_eq("xor_rsp_taken", rsp_q.size(), 0);

    mem[0] = 32'h2001FFFF;
    mem[1] = 32'h0000000D;
    log_q.delete();
    auto_rsp = 1'b1;
    rsp_q.push_back(rsp_t'{data: mem[1], id: 8'd0});
    rsp_q.push_back(rsp_t'{data: mem[0], id: 8'd1});
    for (int i = 0; i < 60 && !ring.io_halted; i++) tick();
    check_eq("brk_halted", ring.io_halted, 1);
    repeat (10) tick();
    check_eq("brk_count", log_q.size(), 1);
    check_eq("brk_id", pk(0).id, 1);
    check_eq("brk_addr", pk(0).addr, 4);

    rst_n = 1'b0; next_rdy = 1'b0; auto_rsp = 1'b0;
    @(posedge clk); #1;
    rsp_q.delete(); log_q.delete(); ring.io_prev_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("pend_valid", ring.io_next_valid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_next_valid", ring.io_next_valid, 0);
    check_eq("midrst_prev_ready", ring.io_prev_ready, 1);
    check_eq("midrst_halted", ring.io_halted, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    tick();
    snap = pkt_t'{addr: ring.io_next_bits_address, data: ring.io_next_bits_data,
                  wen: ring.io_next_bits_wen, id: ring.io_next_bits_id};
    check_eq("restart_addr", snap.addr, 0);
    check_eq("restart_id", snap.id, 1);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!ring.io_next_valid || ring.io_next_bits_address !== snap.addr ||
          ring.io_next_bits_data !== snap.data || ring.io_next_bits_wen !== snap.wen ||
          ring.io_next_bits_id !== snap.id) stable = 1'b0;
    end
    check_eq("hold_stable", stable, 1);
    check_eq("hold_prev_ready", ring.io_prev_ready, 0);
    next_rdy = 1'b1;
    repeat (6) tick();
    check_eq("drain_count", log_q.size(), 2);
    check_eq("drain_id0", pk(0).id, 1);
    check_eq("drain_id1", pk(1).id, 0);
    check_eq("drain_addr1", pk(1).addr, 0);

    log_q.delete();
    rsp_q.push_back(rsp_t'{data: 32'h2001FFFF, id: 8'd5});
    repeat (20) tick();
    check_eq("stray_taken", rsp_q.size(), 0);
    check_eq("stray_no_req", log_q.size(), 0);

    rsp_q.push_back(rsp_t'{data: 32'hFC000000, id: 8'd0});
    repeat (12) tick();
`ifdef MULTICORE_RING_HALT_ON_ILLEGAL_EN
    check_eq("illegal_count", log_q.size(), 0);
`else
    check_eq("illegal_count", log_q.size(), 1);
    check_eq("illegal_addr", pk(0).addr, 4);
    check_eq("illegal_id", pk(0).id, 0);
`endif

    rst_n = 1'b0;
    @(posedge clk); #1;
    rsp_q.delete(); log_q.delete(); ring.io_prev_valid = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = 32'h3C011234; mem[1] = 32'h20215678; mem[2] = 32'h14200001;
    mem[3] = 32'h0000000D; mem[4] = 32'hAC010040; mem[5] = 32'h8C020040;
    mem[6] = 32'hAC020044; mem[7] = 32'h08000003;
    auto_rsp = 1'b1; next_rdy = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 600 && !ring.io_halted; i++) tick();
    check_eq("prog_halted", ring.io_halted, 1);
    exp_addr = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h40, 32'h14, 32'h40, 32'h18, 32'h44, 32'h1C, 32'hC};
    exp_wen  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    nwr = 0;
    foreach (log_q[i]) begin
      if (log_q[i].id == 8'd0) p0.push_back(log_q[i]);
      if (log_q[i].wen) begin
        nwr++;
        check_eq("prog_wr_data", log_q[i].data, 32'h12345678);
      end
    end
    check_eq("prog_wr_count", nwr, 4);
    check_eq("prog_core0_count", p0.size(), 11);
    for (int i = 0; i < 11; i++) begin
      p = (i < p0.size()) ? p0[i] : '1;
      check_eq($sformatf("prog_core0_addr%0d", i), p.addr, exp_addr[i]);
      check_eq($sformatf("prog_core0_wen%0d", i), p.wen, exp_wen[i]);
    end
    check_eq("prog_mem44", mem[17], 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
